// File: rtl/block_interleaver_pkg.sv
// Shared types and elaboration helpers for the block interleaver.
package block_interleaver_pkg;

   typedef enum logic {
      FILL = 1'b0,
      TERM = 1'b1
   } state_e;

   // Block length N = 2^LOG_N.
   function automatic int blk_len(input int log_n);
      return 1 << log_n;
   endfunction

   // QPP needs an odd linear term and an even quadratic term to be a bijection.
   function automatic bit f1_legal(input int f1);
      return (f1 % 2) != 0;
   endfunction

   function automatic bit f2_legal(input int f2);
      return (f2 % 2) == 0;
   endfunction

endpackage

// File: rtl/qpp_addr_gen.sv
// Incremental QPP address generator: pi(i) = (F1*i + F2*i^2) mod 2^LOG_N.
// Uses only adds: pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + 2*F2.
module qpp_addr_gen
   import block_interleaver_pkg::*;
#(
   parameter int LOG_N = 12,
   parameter int F1    = 3,
   parameter int F2    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             restart,
   output logic [LOG_N-1:0] addr
);

   localparam logic [LOG_N-1:0] G0 = LOG_N'(F1 + F2);
   localparam logic [LOG_N-1:0] DG = LOG_N'(2 * F2);

   if (!f1_legal(F1) || !f2_legal(F2)) begin : g_bad_coef
      $error("qpp_addr_gen: F1 must be odd and F2 must be even");
   end

   logic [LOG_N-1:0] pi_q, g_q;

   // Recursion state; restart wins over step so a new block always begins at pi(0).
   always_ff @(posedge clk) begin
      if (!reset) begin
         pi_q <= '0;
         g_q  <= G0;
      end else if (restart) begin
         pi_q <= '0;
         g_q  <= G0;
      end else if (step) begin
         pi_q <= pi_q + g_q;
         g_q  <= g_q + DG;
      end
   end

   assign addr = pi_q;

endmodule

// File: rtl/block_interleaver.sv
// Double-buffered QPP block interleaver. One bank fills while the other
// (previous block) is read out in natural and interleaved order, in lockstep
// with the incoming beats. A fixed termination gap separates blocks.
module block_interleaver
   import block_interleaver_pkg::*;
#(
   parameter int DATA_W   = 1,
   parameter int LOG_N    = 12,
   parameter int F1       = 3,
   parameter int F2       = 4,
   parameter int TERM_GAP = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] dout_nat,
   output logic [DATA_W-1:0] dout_int,
   output logic              out_valid,
   output logic              out_sop,
   output logic              out_eop,
   output logic              mode
);

   localparam int               N     = blk_len(LOG_N);
   localparam logic [LOG_N-1:0] LAST  = LOG_N'(N - 1);
   localparam int               TW    = (TERM_GAP > 1) ? $clog2(TERM_GAP) : 1;
   localparam logic [TW-1:0]    TLAST = TW'(TERM_GAP - 1);

   state_e            state_q, state_d;
   logic              wb_q, wb_d;
   logic              prev_full_q, prev_full_d;
   logic [LOG_N-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]     tcnt_q, tcnt_d;
   logic              gen_restart;
   logic [LOG_N-1:0]  pi;

   logic              in_ready_q, mode_q, out_valid_q, out_sop_q, out_eop_q;
   logic [DATA_W-1:0] dout_nat_q, dout_int_q;

   // Both banks in one array; the top address bit selects the bank.
   logic [DATA_W-1:0] mem_q [0:2*N-1];

   logic accept, rd_en;
   assign accept = in_valid & in_ready_q;
   assign rd_en  = accept & prev_full_q;

   qpp_addr_gen #(.LOG_N(LOG_N), .F1(F1), .F2(F2)) u_qpp (
      .clk     (clk),
      .reset   (reset),
      .step    (accept),
      .restart (gen_restart),
      .addr    (pi)
   );

   // Control state register.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= FILL;
         wb_q        <= 1'b0;
         prev_full_q <= 1'b0;
         cnt_q       <= '0;
         tcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         wb_q        <= wb_d;
         prev_full_q <= prev_full_d;
         cnt_q       <= cnt_d;
         tcnt_q      <= tcnt_d;
      end
   end

   // Next state: count beats in FILL, count gap cycles in TERM, swap banks at gap end.
   always_comb begin
      state_d     = state_q;
      wb_d        = wb_q;
      prev_full_d = prev_full_q;
      cnt_d       = cnt_q;
      tcnt_d      = tcnt_q;
      gen_restart = 1'b0;
      case (state_q)
         FILL: begin
            tcnt_d = '0;
            if (accept) begin
               cnt_d = cnt_q + LOG_N'(1);
               if (cnt_q == LAST) state_d = TERM;
            end
         end
         TERM: begin
            if (tcnt_q == TLAST) begin
               state_d     = FILL;
               wb_d        = ~wb_q;
               prev_full_d = 1'b1;
               cnt_d       = '0;
               gen_restart = 1'b1;
            end else begin
               tcnt_d = tcnt_q + TW'(1);
            end
         end
         default: state_d = FILL;
      endcase
   end

   // Write port: accepted beats land in the fill bank; no reset so it maps to RAM.
   always_ff @(posedge clk) begin
      if (reset && accept) mem_q[{wb_q, cnt_q}] <= din;
   end

   // Registered outputs; flags derive from next state so they line up with the bank reads.
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_ready_q  <= 1'b0;
         mode_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         dout_nat_q  <= '0;
         dout_int_q  <= '0;
      end else begin
         in_ready_q  <= (state_d == FILL);
         mode_q      <= (state_d == TERM);
         out_valid_q <= rd_en;
         out_sop_q   <= rd_en && (cnt_q == '0);
         out_eop_q   <= rd_en && (cnt_q == LAST);
         if (rd_en) begin
            dout_nat_q <= mem_q[{~wb_q, cnt_q}];
            dout_int_q <= mem_q[{~wb_q, pi}];
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign mode      = mode_q;
   assign out_valid = out_valid_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign dout_nat  = dout_nat_q;
   assign dout_int  = dout_int_q;

endmodule

// File: tb/tb_block_interleaver.sv
// Self-checking bench for block_interleaver (N=16, F1=3, F2=4, gap 2).
module tb_block_interleaver;

   localparam int LOG_N = 4, DATA_W = 8, F1 = 3, F2 = 4, TERM_GAP = 2;
   localparam int N = 16;

   logic       clk = 1'b0;
   logic       reset, in_valid, in_ready, out_valid, out_sop, out_eop, mode;
   logic [7:0] din, dout_nat, dout_int;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   block_interleaver #(.DATA_W(DATA_W), .LOG_N(LOG_N), .F1(F1), .F2(F2), .TERM_GAP(TERM_GAP)) dut (
      .clk(clk), .reset(reset), .din(din), .in_valid(in_valid), .in_ready(in_ready),
      .dout_nat(dout_nat), .dout_int(dout_int), .out_valid(out_valid),
      .out_sop(out_sop), .out_eop(out_eop), .mode(mode)
   );

   // Reference model: the block stored last and whether it is complete.
   logic [7:0] blk[N];
   logic [7:0] ref_prev[N];
   bit         ref_pvalid;
   logic [7:0] exp_src[N];
   bit         exp_sv;

   // Observations collected per beat and over the gap.
   logic [7:0] o_nat[N], o_int[N];
   logic       o_val[N], o_sop[N], o_eop[N], o_mode[N], o_rdy[N], o_stall_val[N];
   logic       t_mode[3], t_rdy[3], t_val[3];

   function automatic int pi_of(input int i);
      return (F1 * i + F2 * i * i) % N;
   endfunction

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic fill_rand();
      for (int i = 0; i < N; i++) blk[i] = 8'($urandom);
   endtask

   // Drives nbeats words of blk; optional stall before odd words; optional in_valid held through the gap.
   task automatic drive_block(input int nbeats, input bit toggle, input bit hold);
      exp_src = ref_prev;
      exp_sv  = ref_pvalid;
      for (int i = 0; i < nbeats; i++) begin
         o_stall_val[i] = 1'b0;
         if (toggle && (i % 2 == 1)) begin
            in_valid = 1'b0;
            din      = 8'($urandom);
            step_clk();
            o_stall_val[i] = out_valid;
         end
         o_rdy[i] = in_ready;
         in_valid = 1'b1;
         din      = blk[i];
         step_clk();
         o_val[i]  = out_valid;
         o_nat[i]  = dout_nat;
         o_int[i]  = dout_int;
         o_sop[i]  = out_sop;
         o_eop[i]  = out_eop;
         o_mode[i] = mode;
      end
      in_valid = 1'b0;
      if (nbeats == N) begin
         t_mode[0] = mode; t_rdy[0] = in_ready; t_val[0] = out_valid;
         in_valid = hold;
         din      = 8'hEE;
         for (int t = 1; t < 3; t++) begin
            step_clk();
            t_mode[t] = mode; t_rdy[t] = in_ready; t_val[t] = out_valid;
         end
         in_valid   = 1'b0;
         ref_prev   = blk;
         ref_pvalid = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; in_valid = 1'b0; din = '0;
      ref_pvalid = 1'b0;
      repeat (3) step_clk();
      checks++;
      if ({in_ready, out_valid, out_sop, out_eop, mode, dout_nat, dout_int} !== 21'd0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b vld=%b sop=%b eop=%b mode=%b nat=%0h int=%0h expected all 0",
                  in_ready, out_valid, out_sop, out_eop, mode, dout_nat, dout_int);
      end
      reset = 1'b1; in_valid = 1'b1; din = 8'hAA;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL ready_first_cycle: got %b expected 0", in_ready); end
      step_clk();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_second_cycle: got %b expected 1", in_ready); end
      in_valid = 1'b0;
      for (int i = 0; i < N; i++) blk[i] = 8'(i);
      drive_block(N, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_val[i] !== 1'b0) begin errors++; $display("FAIL first_block_valid[%0d]: got %b expected 0", i, o_val[i]); end
         if (i < N - 1) begin
            checks++;
            if (o_mode[i] !== 1'b0) begin errors++; $display("FAIL first_block_mode[%0d]: got %b expected 0", i, o_mode[i]); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int pi6[6];
      pi6 = '{0, 7, 6, 13, 12, 3};
      for (int i = 0; i < N; i++) blk[i] = 8'(16 + i);
      drive_block(N, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_rdy[i] !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, o_rdy[i]); end
         checks++;
         if (o_val[i] !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, o_val[i]); end
         checks++;
         if (o_nat[i] !== exp_src[i]) begin errors++; $display("FAIL b2b_nat[%0d]: got %0d expected %0d", i, o_nat[i], exp_src[i]); end
         checks++;
         if (o_int[i] !== exp_src[pi_of(i)]) begin errors++; $display("FAIL b2b_int[%0d]: got %0d expected %0d", i, o_int[i], exp_src[pi_of(i)]); end
         checks++;
         if (o_sop[i] !== (i == 0)) begin errors++; $display("FAIL b2b_sop[%0d]: got %b expected %b", i, o_sop[i], (i == 0)); end
         checks++;
         if (o_eop[i] !== (i == N - 1)) begin errors++; $display("FAIL b2b_eop[%0d]: got %b expected %b", i, o_eop[i], (i == N - 1)); end
      end
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (int'(o_int[i]) != pi6[i]) begin errors++; $display("FAIL b2b_pi_table[%0d]: got %0d expected %0d", i, o_int[i], pi6[i]); end
      end
      checks++;
      if ({t_mode[0], t_mode[1], t_mode[2]} !== 3'b110) begin
         errors++; $display("FAIL gap_mode: got %b%b%b expected 110", t_mode[0], t_mode[1], t_mode[2]);
      end
      checks++;
      if ({t_rdy[0], t_rdy[1], t_rdy[2]} !== 3'b001) begin
         errors++; $display("FAIL gap_ready: got %b%b%b expected 001", t_rdy[0], t_rdy[1], t_rdy[2]);
      end
      checks++;
      if ({t_val[1], t_val[2]} !== 2'b00) begin
         errors++; $display("FAIL gap_valid: got %b%b expected 00", t_val[1], t_val[2]);
      end
   endtask

   task automatic test_stall_toggle();
      fill_rand();
      drive_block(N, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_stall_val[i] !== 1'b0) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 0", i, o_stall_val[i]); end
         checks++;
         if (o_val[i] !== 1'b1) begin errors++; $display("FAIL toggle_valid[%0d]: got %b expected 1", i, o_val[i]); end
         checks++;
         if (o_nat[i] !== exp_src[i]) begin errors++; $display("FAIL toggle_nat[%0d]: got %0h expected %0h", i, o_nat[i], exp_src[i]); end
         checks++;
         if (o_int[i] !== exp_src[pi_of(i)]) begin errors++; $display("FAIL toggle_int[%0d]: got %0h expected %0h", i, o_int[i], exp_src[pi_of(i)]); end
      end
   endtask

   task automatic test_hold_through_term();
      fill_rand();
      drive_block(N, 1'b0, 1'b1);
      checks++;
      if ({t_mode[1], t_mode[2], t_rdy[1]} !== 3'b100) begin
         errors++; $display("FAIL hold_gap: got mode=%b%b rdy=%b expected mode=10 rdy=0", t_mode[1], t_mode[2], t_rdy[1]);
      end
      fill_rand();
      drive_block(N, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_nat[i] !== exp_src[i]) begin errors++; $display("FAIL hold_nat[%0d]: got %0h expected %0h", i, o_nat[i], exp_src[i]); end
         checks++;
         if (o_int[i] !== exp_src[pi_of(i)]) begin errors++; $display("FAIL hold_int[%0d]: got %0h expected %0h", i, o_int[i], exp_src[pi_of(i)]); end
      end
      checks++;
      if (o_sop[0] !== 1'b1) begin errors++; $display("FAIL hold_sop: got %b expected 1", o_sop[0]); end
   endtask

   task automatic test_mid_reset();
      fill_rand();
      drive_block(9, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (o_nat[i] !== exp_src[i] || o_val[i] !== 1'b1) begin
            errors++; $display("FAIL midrst_pre[%0d]: got vld=%b nat=%0h expected vld=1 nat=%0h", i, o_val[i], o_nat[i], exp_src[i]);
         end
      end
      reset = 1'b0; in_valid = 1'b1; din = blk[9];
      step_clk();
      checks++;
      if ({in_ready, out_valid, out_sop, out_eop, mode, dout_nat, dout_int} !== 21'd0) begin
         errors++;
         $display("FAIL midrst_outputs: got rdy=%b vld=%b sop=%b eop=%b mode=%b nat=%0h int=%0h expected all 0",
                  in_ready, out_valid, out_sop, out_eop, mode, dout_nat, dout_int);
      end
      reset = 1'b1; in_valid = 1'b0;
      ref_pvalid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready_low: got %b expected 0", in_ready); end
      step_clk();
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_high: got %b expected 1", in_ready); end
      fill_rand();
      drive_block(N, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_val[i] !== 1'b0) begin errors++; $display("FAIL midrst_noout[%0d]: got %b expected 0", i, o_val[i]); end
      end
      fill_rand();
      drive_block(N, 1'b0, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (o_int[i] !== exp_src[pi_of(i)] || o_val[i] !== 1'b1) begin
            errors++; $display("FAIL midrst_after[%0d]: got vld=%b int=%0h expected vld=1 int=%0h", i, o_val[i], o_int[i], exp_src[pi_of(i)]);
         end
      end
   endtask

   task automatic test_permutation();
      int seen[N];
      for (int i = 0; i < N; i++) blk[i] = 8'(i);
      drive_block(N, 1'b0, 1'b0);
      fill_rand();
      drive_block(N, 1'b0, 1'b0);
      for (int v = 0; v < N; v++) seen[v] = 0;
      for (int i = 0; i < N; i++) if (o_val[i] === 1'b1 && o_int[i] < N) seen[o_int[i]]++;
      for (int v = 0; v < N; v++) begin
         checks++;
         if (seen[v] != 1) begin errors++; $display("FAIL perm_count[%0d]: got %0d occurrences expected 1", v, seen[v]); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_back_to_back();
      test_stall_toggle();
      test_hold_through_term();
      test_mid_reset();
      test_permutation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
